// File: rtl/ahir_tx_frame_padder.sv
`timescale 1ns/1ps
// ahir_tx_frame_padder
//
// Buffers words from the AHIR core output pipe and forwards them to the
// out-data pipe of the RIFFA-to-AHIR bridge. The bridge always expects
// complete frames of FRAME_BEATS beats. If the core goes quiet for TIMEOUT
// cycles in the middle of a frame, the rest of that frame is filled with
// PAD_WORD so the PCIe channel never hangs.
//
// Ports:
//   CLK                      sole clock, rising edge
//   RST                      asynchronous, active-high reset
//   core_pipe_write_data     data from core
//   core_pipe_write_req      core has valid data
//   core_pipe_write_ack      block can accept (push = req & ack)
//   out_data_pipe_read_req   bridge has space
//   out_data_pipe_read_data  data to bridge
//   out_data_pipe_read_ack   data valid (beat = req & ack)
//   pad_active               high while the frame is being padded
//   frames_padded            number of padded frames, saturating
module ahir_tx_frame_padder #(
  parameter int                          C_PCI_DATA_WIDTH = 32,
  parameter int                          TX_DATA_LEN      = 120,
  parameter int                          FIFO_DEPTH       = 8,
  parameter int                          TIMEOUT          = 1024,
  parameter logic [C_PCI_DATA_WIDTH-1:0] PAD_WORD         = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [C_PCI_DATA_WIDTH-1:0] core_pipe_write_data,
  input  logic                        core_pipe_write_req,
  output logic                        core_pipe_write_ack,
  input  logic                        out_data_pipe_read_req,
  output logic [C_PCI_DATA_WIDTH-1:0] out_data_pipe_read_data,
  output logic                        out_data_pipe_read_ack,
  output logic                        pad_active,
  output logic [15:0]                 frames_padded
);

  localparam int WORDS_PER_BEAT = C_PCI_DATA_WIDTH / 32;
  localparam int FRAME_BEATS    = TX_DATA_LEN / WORDS_PER_BEAT;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int TMR_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [31:0]      LAST_BEAT = 32'(FRAME_BEATS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [C_PCI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [C_PCI_DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [1:0]                  state_q, state_d;
  logic [31:0]                 beat_cnt_q, beat_cnt_d;
  logic [TMR_W-1:0]            timer_q, timer_d;
  logic [15:0]                 frames_padded_q, frames_padded_d;

  logic full, empty, push, pop, beat, last_beat;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Ack is gated by RST directly so it reads 0 for the whole reset window.
  assign core_pipe_write_ack = ~RST & ~full;
  assign push                = core_pipe_write_req & core_pipe_write_ack;

  always_comb begin
    out_data_pipe_read_ack  = ~empty;
    out_data_pipe_read_data = mem_q[rd_ptr_q];
    if (state_q == S_PAD) begin
      out_data_pipe_read_ack  = 1'b1;
      out_data_pipe_read_data = PAD_WORD;
    end
  end

  assign beat      = out_data_pipe_read_req & out_data_pipe_read_ack;
  // Pad beats are synthesized; the FIFO head is left for the next frame.
  assign pop       = beat & (state_q != S_PAD);
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  assign pad_active    = (state_q == S_PAD);
  assign frames_padded = frames_padded_q;

  // FIFO storage and pointers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = core_pipe_write_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame FSM, beat counter and idle timer
  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    timer_d         = timer_q;
    frames_padded_d = frames_padded_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (beat) begin
          if (last_beat) begin
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            state_d    = S_PASS;
          end
        end
      end
      S_PASS: begin
        if (beat) begin
          timer_d = '0;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
          end
        end else if (push) begin
          // A push in the expiry cycle keeps the frame alive.
          timer_d = '0;
        end else if (empty) begin
          if (timer_q == TMR_LAST) begin
            timer_d = '0;
            state_d = S_PAD;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        // Non-empty without a beat means the bridge is stalling: hold.
      end
      S_PAD: begin
        timer_d = '0;
        if (beat) begin
          if (last_beat) begin
            beat_cnt_d      = '0;
            state_d         = S_IDLE;
            frames_padded_d = sat_inc16(frames_padded_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
        timer_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= S_IDLE;
      beat_cnt_q      <= '0;
      timer_q         <= '0;
      frames_padded_q <= '0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      timer_q         <= timer_d;
      frames_padded_q <= frames_padded_d;
    end
  end

endmodule

// File: tb/tb_ahir_tx_frame_padder.sv
`timescale 1ns/1ps
// Testbench for ahir_tx_frame_padder: directed scenarios plus randomized
// traffic checked against a frame-level reference model (queue of buffered
// words, position within frame, quiet-cycle count, padding flag).
module tb_ahir_tx_frame_padder;

  localparam int          DW    = 32;
  localparam int          FB    = 4;
  localparam int          DEPTH = 8;
  localparam int          TO    = 16;
  localparam logic [31:0] PADW  = 32'hDEAD_BEEF;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] core_pipe_write_data = '0;
  logic          core_pipe_write_req = 1'b0;
  logic          core_pipe_write_ack;
  logic          out_data_pipe_read_req = 1'b0;
  logic [DW-1:0] out_data_pipe_read_data;
  logic          out_data_pipe_read_ack;
  logic          pad_active;
  logic [15:0]   frames_padded;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] mq[$];
  int          m_pos     = 0;
  int          m_quiet   = 0;
  bit          m_padding = 1'b0;
  int          m_padded  = 0;

  ahir_tx_frame_padder #(
    .C_PCI_DATA_WIDTH(DW),
    .TX_DATA_LEN(FB),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TO),
    .PAD_WORD(PADW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .core_pipe_write_data(core_pipe_write_data),
    .core_pipe_write_req(core_pipe_write_req),
    .core_pipe_write_ack(core_pipe_write_ack),
    .out_data_pipe_read_req(out_data_pipe_read_req),
    .out_data_pipe_read_data(out_data_pipe_read_data),
    .out_data_pipe_read_ack(out_data_pipe_read_ack),
    .pad_active(pad_active),
    .frames_padded(frames_padded)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    mq.delete();
    m_pos     = 0;
    m_quiet   = 0;
    m_padding = 1'b0;
    m_padded  = 0;
  endfunction

  // One clock of the frame-level model.
  function automatic void model_adv(input bit push, input logic [31:0] wd, input bit beat);
    bit was_empty;
    was_empty = (mq.size() == 0);
    if (beat) begin
      if (!m_padding) void'(mq.pop_front());
      m_pos++;
      m_quiet = 0;
      if (m_pos == FB) begin
        m_pos = 0;
        if (m_padding) begin
          m_padding = 1'b0;
          if (m_padded < 65535) m_padded++;
        end
      end
    end else if (m_pos > 0 && !m_padding) begin
      if (push) m_quiet = 0;
      else if (was_empty) begin
        m_quiet++;
        if (m_quiet == TO) begin
          m_padding = 1'b1;
          m_quiet   = 0;
        end
      end
    end
    if (push) mq.push_back(wd);
  endfunction

  // Drive one cycle of inputs; returns #1 after the rising edge.
  task automatic step(input bit wreq, input logic [31:0] wd, input bit rreq);
    bit push, beat;
    core_pipe_write_req    = wreq;
    core_pipe_write_data   = wd;
    out_data_pipe_read_req = rreq;
    push = wreq && (mq.size() < DEPTH);
    beat = rreq && (m_padding || mq.size() > 0);
    @(posedge CLK);
    model_adv(push, wd, beat);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    core_pipe_write_req = 1'b0;
    out_data_pipe_read_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (core_pipe_write_ack !== 1'b0) begin bad++; $display("FAIL rst_wack: got %b want 0", core_pipe_write_ack); end
    total++; if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL rst_rack: got %b want 0", out_data_pipe_read_ack); end
    total++; if (out_data_pipe_read_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data_pipe_read_data); end
    total++; if (pad_active !== 1'b0) begin bad++; $display("FAIL rst_pad: got %b want 0", pad_active); end
    total++; if (frames_padded !== 16'h0) begin bad++; $display("FAIL rst_fp: got %0d want 0", frames_padded); end
    RST = 1'b0;
    model_reset();
    #1;
    total++; if (core_pipe_write_ack !== 1'b1) begin bad++; $display("FAIL rst_release_wack: got %b want 1", core_pipe_write_ack); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[8];
    bit padseen;
    padseen = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    for (int c = 0; c < 10; c++) begin
      if (c >= 1 && c <= 8) begin
        total++;
        if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== w[c-1]) begin
          bad++; $display("FAIL b2b_beat%0d: got ack=%b data=%h want ack=1 data=%h", c, out_data_pipe_read_ack, out_data_pipe_read_data, w[c-1]);
        end
      end else begin
        total++;
        if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d: got ack=%b want 0", c, out_data_pipe_read_ack); end
      end
      if (pad_active) padseen = 1'b1;
      step(c < 8, (c < 8) ? w[c] : 32'h0, 1'b1);
    end
    total++; if (padseen !== 1'b0) begin bad++; $display("FAIL b2b_pad: got %b want 0", padseen); end
    total++; if (frames_padded !== 16'd0) begin bad++; $display("FAIL b2b_fp: got %0d want 0", frames_padded); end
  endtask

  task automatic test_timeout_pad();
    logic [31:0] w;
    bit e_ack, e_pad;
    logic [15:0] e_fp;
    w = $urandom;
    for (int c = 0; c < 23; c++) begin
      e_pad = (c >= 18 && c <= 20);
      e_ack = (c == 1) || e_pad;
      e_fp  = (c >= 21) ? 16'd1 : 16'd0;
      total++; if (out_data_pipe_read_ack !== e_ack) begin bad++; $display("FAIL to_ack%0d: got %b want %b", c, out_data_pipe_read_ack, e_ack); end
      total++; if (pad_active !== e_pad) begin bad++; $display("FAIL to_pad%0d: got %b want %b", c, pad_active, e_pad); end
      total++; if (frames_padded !== e_fp) begin bad++; $display("FAIL to_fp%0d: got %0d want %0d", c, frames_padded, e_fp); end
      if (c == 1) begin
        total++; if (out_data_pipe_read_data !== w) begin bad++; $display("FAIL to_data: got %h want %h", out_data_pipe_read_data, w); end
      end
      if (e_pad) begin
        total++; if (out_data_pipe_read_data !== PADW) begin bad++; $display("FAIL to_padword%0d: got %h want %h", c, out_data_pipe_read_data, PADW); end
      end
      step(c == 0, w, 1'b1);
    end
  endtask

  task automatic test_full_no_pad();
    logic [31:0] w[9];
    int padcnt, ackdrop;
    padcnt = 0;
    ackdrop = 0;
    for (int i = 0; i < 9; i++) w[i] = $urandom;
    for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0);
    total++; if (core_pipe_write_ack !== 1'b0) begin bad++; $display("FAIL full_wack: got %b want 0", core_pipe_write_ack); end
    step(1'b1, 32'hBAD0_0BAD, 1'b0);
    total++; if (core_pipe_write_ack !== 1'b0) begin bad++; $display("FAIL full_wack2: got %b want 0", core_pipe_write_ack); end
    total++; if (out_data_pipe_read_data !== w[0]) begin bad++; $display("FAIL full_head: got %h want %h", out_data_pipe_read_data, w[0]); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (core_pipe_write_ack !== 1'b1) begin bad++; $display("FAIL full_wack3: got %b want 1", core_pipe_write_ack); end
    step(1'b1, w[8], 1'b0);
    repeat (2000) begin
      step(1'b0, 32'h0, 1'b0);
      if (pad_active !== 1'b0) padcnt++;
      if (out_data_pipe_read_ack !== 1'b1) ackdrop++;
    end
    total++; if (padcnt !== 0) begin bad++; $display("FAIL stall_pad: got %0d pad cycles want 0", padcnt); end
    total++; if (ackdrop !== 0) begin bad++; $display("FAIL stall_ack: got %0d ack drops want 0", ackdrop); end
    for (int c = 0; c < 41; c++) begin
      if (c < 8) begin
        total++; if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== w[c+1]) begin
          bad++; $display("FAIL drain%0d: got ack=%b data=%h want ack=1 data=%h", c, out_data_pipe_read_ack, out_data_pipe_read_data, w[c+1]);
        end
      end
      total++; if (pad_active !== m_padding) begin bad++; $display("FAIL drain_pad%0d: got %b want %b", c, pad_active, m_padding); end
      total++; if (frames_padded !== 16'(m_padded)) begin bad++; $display("FAIL drain_fp%0d: got %0d want %0d", c, frames_padded, m_padded); end
      step(1'b0, 32'h0, 1'b1);
    end
    total++; if (frames_padded !== 16'd2) begin bad++; $display("FAIL drain_fp_end: got %0d want 2", frames_padded); end
  endtask

  task automatic test_push_at_expiry();
    logic [31:0] wa, wb, wc, wd;
    logic [15:0] fp0;
    bit wr;
    logic [31:0] dv;
    wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
    fp0 = 16'(m_padded);
    for (int c = 0; c < 22; c++) begin
      if (c >= 17) begin
        total++; if (pad_active !== 1'b0) begin bad++; $display("FAIL exp_pad%0d: got %b want 0", c, pad_active); end
      end
      if (c == 18) begin
        total++; if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== wb) begin
          bad++; $display("FAIL exp_word: got ack=%b data=%h want ack=1 data=%h", out_data_pipe_read_ack, out_data_pipe_read_data, wb);
        end
      end
      if (c == 20) begin
        total++; if (out_data_pipe_read_data !== wd) begin bad++; $display("FAIL exp_last: got %h want %h", out_data_pipe_read_data, wd); end
      end
      if (c == 21) begin
        total++; if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL exp_end_ack: got %b want 0", out_data_pipe_read_ack); end
      end
      wr = (c == 0) || (c >= 17 && c <= 19);
      dv = (c == 0) ? wa : (c == 17) ? wb : (c == 18) ? wc : wd;
      step(wr, dv, 1'b1);
    end
    total++; if (frames_padded !== fp0) begin bad++; $display("FAIL exp_fp: got %0d want %0d", frames_padded, fp0); end
  endtask

  task automatic test_push_during_pad();
    logic [31:0] wa, wp, wq, wr2, ws;
    logic [15:0] fp0;
    bit wr, e_pad;
    logic [31:0] dv;
    wa = $urandom; wp = $urandom; wq = $urandom; wr2 = $urandom; ws = $urandom;
    fp0 = 16'(m_padded);
    for (int c = 0; c < 27; c++) begin
      e_pad = (c >= 18 && c <= 20);
      total++; if (pad_active !== e_pad) begin bad++; $display("FAIL pp_pad%0d: got %b want %b", c, pad_active, e_pad); end
      if (e_pad) begin
        total++; if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== PADW) begin
          bad++; $display("FAIL pp_padword%0d: got ack=%b data=%h want ack=1 data=%h", c, out_data_pipe_read_ack, out_data_pipe_read_data, PADW);
        end
      end
      if (c == 21) begin
        total++; if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== wp) begin
          bad++; $display("FAIL pp_next: got ack=%b data=%h want ack=1 data=%h", out_data_pipe_read_ack, out_data_pipe_read_data, wp);
        end
        total++; if (frames_padded !== fp0 + 16'd1) begin bad++; $display("FAIL pp_fp: got %0d want %0d", frames_padded, fp0 + 16'd1); end
      end
      if (c == 25) begin
        total++; if (out_data_pipe_read_data !== ws) begin bad++; $display("FAIL pp_last: got %h want %h", out_data_pipe_read_data, ws); end
      end
      if (c == 26) begin
        total++; if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL pp_end_ack: got %b want 0", out_data_pipe_read_ack); end
      end
      wr = (c == 0) || (c == 18) || (c >= 22 && c <= 24);
      dv = (c == 0) ? wa : (c == 18) ? wp : (c == 22) ? wq : (c == 23) ? wr2 : ws;
      step(wr, dv, 1'b1);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w[4];
    logic [31:0] v[4];
    int padcnt;
    padcnt = 0;
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; v[i] = $urandom; end
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0);
    step(1'b0, 32'h0, 1'b1);
    total++; if (out_data_pipe_read_data !== w[1]) begin bad++; $display("FAIL mid_head: got %h want %h", out_data_pipe_read_data, w[1]); end
    out_data_pipe_read_req = 1'b0;
    RST = 1'b1;
    #1;
    total++; if (core_pipe_write_ack !== 1'b0) begin bad++; $display("FAIL mid_wack: got %b want 0", core_pipe_write_ack); end
    total++; if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL mid_rack: got %b want 0", out_data_pipe_read_ack); end
    total++; if (out_data_pipe_read_data !== 32'h0) begin bad++; $display("FAIL mid_data: got %h want 0", out_data_pipe_read_data); end
    total++; if (pad_active !== 1'b0) begin bad++; $display("FAIL mid_pad: got %b want 0", pad_active); end
    total++; if (frames_padded !== 16'd0) begin bad++; $display("FAIL mid_fp: got %0d want 0", frames_padded); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    for (int c = 0; c < 27; c++) begin
      if (c >= 1 && c <= 4) begin
        total++; if (out_data_pipe_read_ack !== 1'b1 || out_data_pipe_read_data !== v[c-1]) begin
          bad++; $display("FAIL fresh%0d: got ack=%b data=%h want ack=1 data=%h", c, out_data_pipe_read_ack, out_data_pipe_read_data, v[c-1]);
        end
      end else if (c == 0 || c == 5) begin
        total++; if (out_data_pipe_read_ack !== 1'b0) begin bad++; $display("FAIL fresh_idle%0d: got %b want 0", c, out_data_pipe_read_ack); end
      end
      if (pad_active !== 1'b0) padcnt++;
      step(c < 4, (c < 4) ? v[c] : 32'h0, 1'b1);
    end
    total++; if (padcnt !== 0) begin bad++; $display("FAIL fresh_pad: got %0d pad cycles want 0", padcnt); end
  endtask

  task automatic test_random();
    int wp, rp, phase;
    bit e_wack, e_rack;
    logic [31:0] e_data;
    for (int i = 0; i < 3000; i++) begin
      e_wack = (mq.size() < DEPTH);
      e_rack = m_padding || (mq.size() > 0);
      total++; if (core_pipe_write_ack !== e_wack) begin bad++; $display("FAIL rnd_wack@%0d: got %b want %b", i, core_pipe_write_ack, e_wack); end
      total++; if (out_data_pipe_read_ack !== e_rack) begin bad++; $display("FAIL rnd_rack@%0d: got %b want %b", i, out_data_pipe_read_ack, e_rack); end
      total++; if (pad_active !== m_padding) begin bad++; $display("FAIL rnd_pad@%0d: got %b want %b", i, pad_active, m_padding); end
      total++; if (frames_padded !== 16'(m_padded)) begin bad++; $display("FAIL rnd_fp@%0d: got %0d want %0d", i, frames_padded, m_padded); end
      if (e_rack) begin
        e_data = m_padding ? PADW : mq[0];
        total++; if (out_data_pipe_read_data !== e_data) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data_pipe_read_data, e_data); end
      end
      phase = (i / 250) % 3;
      wp = (phase == 0) ? 90 : (phase == 1) ? 40 : 4;
      rp = (phase == 2) ? 95 : 70;
      step($urandom_range(99) < wp, $urandom, $urandom_range(99) < rp);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout_pad();
    test_full_no_pad();
    test_push_at_expiry();
    test_push_during_pad();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
